// File: rtl/dtc_sched_pkg.sv
// Shared types and helpers for the decision-tree classifier share scheduler.
//   sched_state_e : scheduler FSM states (IDLE, EVAL, HOLD)
//   FEAT_W_DEF / CLS_W_DEF : default feature / class widths
//   rr_pick()     : round-robin pick over up to RR_MAX requesters, searching
//                   from last+1 upward with wrap to 0
package dtc_sched_pkg;

  localparam int FEAT_W_DEF = 8;
  localparam int CLS_W_DEF  = 2;
  localparam int RR_MAX     = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    HOLD = 2'd2
  } sched_state_e;

  // Returns the first valid index after 'last' (mod n). Returns 0 when
  // nothing is valid; callers qualify the result with |valid.
  function automatic logic [3:0] rr_pick(input logic [RR_MAX-1:0] valid,
                                         input logic [3:0]        last,
                                         input int unsigned       n);
    logic [3:0]  pick;
    logic        found;
    int unsigned idx;
    pick  = 4'd0;
    found = 1'b0;
    for (int unsigned k = 1; k <= RR_MAX; k++) begin
      idx = (32'(last) + k) % n;
      if (!found && (k <= n) && valid[idx[3:0]]) begin
        pick  = idx[3:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/dtc_rr_arbiter.sv
// Round-robin arbiter with its own last-granted pointer.
//   clk, rst   : clock, synchronous active-high reset (last -> NREQ-1)
//   req_valid  : per-requester valid
//   upd        : a grant was accepted this cycle; move last to the grant
//   grant_oh   : one-hot grant (zero when nothing is valid)
//   grant_idx  : binary index of the grant
module dtc_rr_arbiter
  import dtc_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_valid,
  input  logic            upd,
  output logic [NREQ-1:0] grant_oh,
  output logic [ID_W-1:0] grant_idx
);

  logic [ID_W-1:0] last_q, last_d;
  logic [3:0]      pick;

  always_comb begin
    pick                = rr_pick(16'(req_valid), 4'(last_q), NREQ);
    grant_idx           = pick[ID_W-1:0];
    grant_oh            = '0;
    grant_oh[grant_idx] = |req_valid;
    // Pointer moves only on an accepted grant, so a requester that drops
    // out before being served does not disturb the rotation.
    last_d              = upd ? grant_idx : last_q;
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= ID_W'(NREQ - 1);
    else     last_q <= last_d;
  end

endmodule

// File: rtl/dtc_share_sched.sv
// Time-shares one external combinational decision-tree classifier between
// NREQ requesters. The winning feature vector is registered onto cls_feat,
// the class is captured one cycle later, and {class, id} is returned on a
// valid/ready result stream.
//   clk, rst             : clock, synchronous active-high reset
//   req_valid/req_ready  : per-requester handshake (req_ready one-hot or 0)
//   req_feat             : packed features, requester i at [i*FEAT_W +: FEAT_W]
//   cls_feat / cls_class : to / from the classifier
//   res_valid/res_ready  : result handshake; res_class, res_id payload
//   stat_clr / stat_cnt  : per-class result counters, only when the macro
//                          DTC_SCHED_STATS_EN is defined
module dtc_share_sched
  import dtc_sched_pkg::*;
#(
  parameter  int NREQ   = 4,
  parameter  int FEAT_W = FEAT_W_DEF,
  parameter  int CLS_W  = CLS_W_DEF,
  parameter  int CNT_W  = 16,
  localparam int ID_W   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*FEAT_W-1:0]   req_feat,
  output logic [FEAT_W-1:0]        cls_feat,
  input  logic [CLS_W-1:0]         cls_class,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [CLS_W-1:0]         res_class,
  output logic [ID_W-1:0]          res_id
`ifdef DTC_SCHED_STATS_EN
  ,
  input  logic                     stat_clr,
  output logic [(1<<CLS_W)*CNT_W-1:0] stat_cnt
`endif
);

  sched_state_e                   state_q, state_d;
  logic [FEAT_W-1:0]              cls_feat_q, cls_feat_d;
  logic [ID_W-1:0]                id_q, id_d;
  logic [ID_W-1:0]                res_id_q, res_id_d;
  logic [CLS_W-1:0]               res_class_q, res_class_d;
  logic                           res_valid_q, res_valid_d;
  logic [NREQ-1:0]                gnt_oh;
  logic [ID_W-1:0]                gnt_idx;
  logic [NREQ-1:0][FEAT_W-1:0]    feat_arr;
  logic                           accept_ok, accept;

  assign feat_arr  = req_feat;
  // A new request may enter while idle, or in the same cycle the held
  // result leaves, which gives one result every two cycles at peak.
  assign accept_ok = (state_q == IDLE) | ((state_q == HOLD) & res_ready);
  assign accept    = accept_ok & (|req_valid);
  assign req_ready = gnt_oh & {NREQ{accept}};

  dtc_rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .upd       (accept),
    .grant_oh  (gnt_oh),
    .grant_idx (gnt_idx)
  );

  always_comb begin
    state_d     = state_q;
    cls_feat_d  = cls_feat_q;
    id_d        = id_q;
    res_id_d    = res_id_q;
    res_class_d = res_class_q;
    res_valid_d = res_valid_q;
    if (accept) begin
      cls_feat_d = feat_arr[gnt_idx];
      id_d       = gnt_idx;
    end
    case (state_q)
      IDLE: if (accept) state_d = EVAL;
      EVAL: begin
        // cls_feat settled during this cycle; capture the classifier output.
        res_class_d = cls_class;
        res_id_d    = id_q;
        res_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: if (res_ready) begin
        res_valid_d = 1'b0;
        state_d     = accept ? EVAL : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cls_feat_q  <= '0;
      id_q        <= '0;
      res_id_q    <= '0;
      res_class_q <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cls_feat_q  <= cls_feat_d;
      id_q        <= id_d;
      res_id_q    <= res_id_d;
      res_class_q <= res_class_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign cls_feat  = cls_feat_q;
  assign res_valid = res_valid_q;
  assign res_class = res_class_q;
  assign res_id    = res_id_q;

`ifdef DTC_SCHED_STATS_EN
  localparam int NCLS = 1 << CLS_W;
  logic [NCLS-1:0][CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    // Clear has priority over a coincident result handshake.
    if (stat_clr)
      cnt_d = '0;
    else if (res_valid_q && res_ready && !(&cnt_q[res_class_q]))
      cnt_d[res_class_q] = cnt_q[res_class_q] + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign stat_cnt = cnt_q;
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_dtc_share_sched.sv
module tb_dtc_share_sched;
  localparam int NREQ = 4, FEAT_W = 8, CLS_W = 2, ID_W = 2, CNT_W = 2, NCLS = 4;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NREQ-1:0]        req_valid = '0;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*FEAT_W-1:0] req_feat = '0;
  logic [FEAT_W-1:0]      cls_feat;
  logic [CLS_W-1:0]       cls_class;
  logic                   res_valid;
  logic                   res_ready = 1'b0;
  logic [CLS_W-1:0]       res_class;
  logic [ID_W-1:0]        res_id;
`ifdef DTC_SCHED_STATS_EN
  logic                   stat_clr = 1'b0;
  logic [NCLS*CNT_W-1:0]  stat_cnt;
`endif

  always #5 clk = ~clk;

  // Stand-in for the attached decision-tree classifier: split on feature
  // bit 6, then bit 3. 00->00, 08->01, 48->00, 40->10.
  function automatic logic [1:0] dt_cls(input logic [7:0] f);
    if (!f[6]) return f[3] ? 2'b01 : 2'b00;
    else       return f[3] ? 2'b00 : 2'b10;
  endfunction
  assign cls_class = dt_cls(cls_feat);

  dtc_share_sched #(.NREQ(NREQ), .FEAT_W(FEAT_W), .CLS_W(CLS_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_feat(req_feat),
    .cls_feat(cls_feat), .cls_class(cls_class),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_class(res_class), .res_id(res_id)
`ifdef DTC_SCHED_STATS_EN
    , .stat_clr(stat_clr), .stat_cnt(stat_cnt)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // At most one request is ever in flight: it becomes visible as a result two
  // cycles after its accept cycle and stays until handshaken.
  int        cyc = 0;
  int        acc_t = -100;
  int        outst = 0;
  int        last_m = NREQ - 1;
  logic [7:0] q_feat;
  logic [1:0] q_cls;
  logic [1:0] q_id;
  int        cnt_m[NCLS];
  int        hs_id[$];
  int        hs_cls[$];
  int        hs_t[$];

  function automatic int rr_ref(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      outst  = 0;
      acc_t  = -100;
      last_m = NREQ - 1;
      for (int k = 0; k < NCLS; k++) cnt_m[k] = 0;
    end else begin
      automatic bit exp_rv  = (outst > 0) && (cyc - acc_t >= 2);
      automatic bit exp_rdy = (|req_valid) && (outst == 0 || (exp_rv && res_ready));
      automatic int g = rr_ref(req_valid, last_m);
      automatic logic [NREQ-1:0] exp_rr = '0;
      if (exp_rdy) exp_rr[g] = 1'b1;
      chk("res_valid", 64'(res_valid), 64'(exp_rv));
      if (exp_rv) begin
        chk("res_class", 64'(res_class), 64'(q_cls));
        chk("res_id", 64'(res_id), 64'(q_id));
      end
      if (outst > 0 && cyc == acc_t + 1) chk("cls_feat", 64'(cls_feat), 64'(q_feat));
      chk("req_ready", 64'(req_ready), 64'(exp_rr));
`ifdef DTC_SCHED_STATS_EN
      for (int k = 0; k < NCLS; k++)
        chk($sformatf("stat_cnt%0d", k), 64'(stat_cnt[k*CNT_W +: CNT_W]), 64'(cnt_m[k]));
      if (stat_clr) begin
        for (int k = 0; k < NCLS; k++) cnt_m[k] = 0;
      end else if (exp_rv && res_ready && cnt_m[q_cls] < (1 << CNT_W) - 1) begin
        cnt_m[q_cls]++;
      end
`endif
      if (exp_rv && res_ready) begin
        outst = 0;
        hs_id.push_back(int'(q_id));
        hs_cls.push_back(int'(q_cls));
        hs_t.push_back(cyc);
      end
      if (exp_rdy) begin
        outst  = 1;
        q_feat = req_feat[g*FEAT_W +: FEAT_W];
        q_cls  = dt_cls(q_feat);
        q_id   = 2'(g);
        last_m = g;
        acc_t  = cyc;
      end
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic wait_acc(input string name, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (|(req_ready & req_valid)) ok = 1'b1;
    end
    if (!ok) chk({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic wait_hs(input int n, input string name);
    for (int c = 0; c < 100 && hs_id.size() < n; c++) tick();
    if (hs_id.size() < n) chk({name, "_timeout"}, 64'(hs_id.size()), 64'(n));
  endtask

  initial begin
    automatic bit ok;
    automatic logic [NREQ-1:0] acc;
    automatic logic [1:0] hc, hi;
    automatic int n;
    automatic int exp_cls[4] = '{0, 1, 0, 2};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_class", 64'(res_class), 64'd0);
    chk("rst_res_id", 64'(res_id), 64'd0);
    chk("rst_cls_feat", 64'(cls_feat), 64'd0);

    // Single request from requester 0
    tick();
    req_feat[7:0] = 8'h40; req_valid = 4'b0001; res_ready = 1'b1;
    wait_acc("t1", ok);
    tick(); req_valid = '0;
    @(negedge clk); chk("t1_eval_rv", 64'(res_valid), 64'd0);
    @(negedge clk);
    chk("t1_rv", 64'(res_valid), 64'd1);
    chk("t1_cls", 64'(res_class), 64'h2);
    chk("t1_id", 64'(res_id), 64'd0);
    tick(); tick();

    // All four held valid: strict rotation, one result every 2 cycles
    do_reset();
    hs_id.delete(); hs_cls.delete(); hs_t.delete();
    req_feat = {8'h40, 8'h48, 8'h08, 8'h00}; req_valid = 4'hF; res_ready = 1'b1;
    wait_hs(8, "t2");
    for (int i = 0; i < 8 && i < hs_id.size(); i++) begin
      chk($sformatf("t2_id%0d", i), 64'(hs_id[i]), 64'(i % 4));
      chk($sformatf("t2_cls%0d", i), 64'(hs_cls[i]), 64'(exp_cls[i % 4]));
      if (i > 0) chk($sformatf("t2_gap%0d", i), 64'(hs_t[i] - hs_t[i-1]), 64'd2);
    end

    // Backpressure in HOLD
    res_ready = 1'b0;
    for (int c = 0; c < 10 && !res_valid; c++) tick();
    @(negedge clk);
    hc = res_class; hi = res_id;
    for (int c = 0; c < 5; c++) begin
      chk("t3_rv", 64'(res_valid), 64'd1);
      chk("t3_cls", 64'(res_class), 64'(hc));
      chk("t3_id", 64'(res_id), 64'(hi));
      chk("t3_rdy", 64'(req_ready), 64'd0);
      @(negedge clk);
    end
    tick(); res_ready = 1'b1;

    // Fairness: req2 streaming, req1 raised later
    do_reset();
    req_valid = 4'b0100;
    repeat (6) tick();
    req_valid = 4'b0110;
    n = 0; ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (|(req_ready & req_valid)) n++;
      if (req_ready[1]) ok = 1'b1;
    end
    chk("t4_granted", 64'(ok), 64'd1);
    chk("t4_within2", 64'(n <= 2), 64'd1);

    // Reset mid-EVAL
    tick();
    req_valid = 4'hF;
    wait_acc("t5", ok);
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    @(negedge clk);
    chk("t5_rv", 64'(res_valid), 64'd0);
    chk("t5_gnt0", 64'(req_ready), 64'b0001);

`ifdef DTC_SCHED_STATS_EN
    // Saturation and clear-wins
    tick();
    do_reset();
    hs_id.delete();
    req_feat[7:0] = 8'h40; req_valid = 4'b0001; res_ready = 1'b1;
    wait_hs(5, "t6");
    res_ready = 1'b0;
    for (int c = 0; c < 10 && !res_valid; c++) tick();
    @(negedge clk);
    chk("t6_sat", 64'(stat_cnt[5:4]), 64'h3);
    tick(); res_ready = 1'b1; stat_clr = 1'b1;
    tick(); stat_clr = 1'b0; res_ready = 1'b0;
    @(negedge clk);
    chk("t6_clr", 64'(stat_cnt), 64'd0);
    tick(); res_ready = 1'b1;
`endif

    // Randomized traffic; features held while valid and unaccepted
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      tick();
      res_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 499) == 0);
`ifdef DTC_SCHED_STATS_EN
      stat_clr = ($urandom_range(0, 63) == 0);
`endif
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && !acc[i]) begin
          if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
        end else begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          req_feat[i*FEAT_W +: FEAT_W] = 8'($urandom);
        end
      end
    end
    rst = 1'b0;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d miscompares %0d", vectors, miscompares);
    $fatal(1, "watchdog");
  end

endmodule
